// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_ACCESS   = 2'd2
  } fetch_cause_t;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word request at a time,
// latches the response into ir, handles redirects and reports fetch faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  import fetch_unit_pkg::*;

  fetch_state_t state_q, state_d;
  fetch_cause_t cause_q, cause_d;
  logic         squash_q, squash_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic         ir_valid_q, ir_valid_d;
  logic         fault_q, fault_d;

  // Request port is decoded from state; held low throughout reset.
  always_comb begin
    mem_req  = (state_q == S_REQ) && !rst;
    mem_addr = pc_q;
  end

  // Next-state logic; redirect overrides every state.
  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;
    cause_d    = cause_q;

    if (redirect) begin
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      squash_d   = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
        cause_d = FC_MISALIGN;
        ir_pc_d = redirect_pc;
        state_d = S_FAULT;
      end else begin
        fault_d = 1'b0;
        cause_d = FC_NONE;
        // An outstanding (or just-granted) request must be drained and dropped.
        if ((state_q == S_WAIT) && mem_rvalid) begin
          state_d = S_REQ;
        end else if ((state_q == S_WAIT) || ((state_q == S_REQ) && mem_gnt)) begin
          squash_d = 1'b1;
          state_d  = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (mem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = S_REQ;
            end else if (mem_err) begin
              fault_d = 1'b1;
              cause_d = FC_ACCESS;
              ir_pc_d = pc_q;
              state_d = S_FAULT;
            end else begin
              ir_d       = mem_rdata;
              ir_pc_d    = pc_q;
              ir_valid_d = 1'b1;
              pc_d       = pc_q + 32'd4;
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            ir_valid_d = 1'b0;
            state_d    = S_REQ;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      squash_q   <= 1'b0;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= FC_NONE;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
    end
  end

  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

  // A response is only legal while a request is outstanding; stray ones are ignored.
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
    mem_rvalid |-> (state_q == S_WAIT));

endmodule
